reg_file_mp: RTL

- Parametrised multi-port architectural register file for the ARM pipeline. Successor to the single-write, two-read register file.
- Provides NUM_READ combinational read ports and two synchronous write ports:
  - port 0: WB-stage result;
  - port 1: base-register writeback / second load result.
- A sequential initialisation engine fills every register with its reset pattern after reset. This avoids an asynchronous clear of the storage array, and `ready` signals completion.
- Optional same-cycle write-to-read bypass replaces the old negedge-write trick.

---
 rtl/reg_file_mp.sv | 71 +++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file, two write ports, sequential init engine after reset.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding (port 0 over port 1).
module reg_file_mp #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 16,
   parameter int NUM_READ   = 3,
   parameter int INIT_INDEX = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_READ*$clog2(DEPTH)-1:0]  rd_addr,
   output logic [NUM_READ*WIDTH-1:0]          rd_data,
   input  logic                               wr0_en,
   input  logic [$clog2(DEPTH)-1:0]           wr0_addr,
   input  logic [WIDTH-1:0]                   wr0_data,
   input  logic                               wr1_en,
   input  logic [$clog2(DEPTH)-1:0]           wr1_addr,
   input  logic [WIDTH-1:0]                   wr1_data,
   output logic                               ready,
   output logic                               wr_conflict
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] S_INIT  = 1'b0;
   localparam logic [0:0] S_READY = 1'b1;
   logic [0:0]       r_state;
   logic [AW-1:0]    r_init_ptr;
   logic             r_ready;
   logic             r_conflict;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] w_pattern;
   assign w_pattern   = (INIT_INDEX != 0) ? WIDTH'(r_init_ptr) : '0;
   assign ready       = r_ready;
   assign wr_conflict = r_conflict;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_INIT;
         r_init_ptr <= '0;
         r_ready    <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_conflict <= (r_state == S_READY) && wr0_en && wr1_en && (wr0_addr == wr1_addr);
         if (r_state == S_INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
            if (r_init_ptr == AW'(DEPTH - 1)) begin
               r_state <= S_READY;
               r_ready <= 1'b1;
            end
         end
      end
   end
   // Array has no reset; the init engine fills it instead. Port 0 written last so it wins.
   always_ff @(posedge clk) begin
      if (r_state == S_INIT) r_mem[r_init_ptr] <= w_pattern;
      else begin
         if (wr1_en) r_mem[wr1_addr] <= wr1_data;
         if (wr0_en) r_mem[wr0_addr] <= wr0_data;
      end
   end
   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [AW-1:0]    w_addr;
      logic [WIDTH-1:0] w_val;
      assign w_addr = rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign w_val = (wr0_en && wr0_addr == w_addr) ? wr0_data :
                     (wr1_en && wr1_addr == w_addr) ? wr1_data : r_mem[w_addr];
`else
      assign w_val = r_mem[w_addr];
`endif
      assign rd_data[k*WIDTH +: WIDTH] = r_ready ? w_val : '0;
   end
endmodule
